// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle for booth_multiplier; the master drives the start pulse and operands.
// No backpressure: a start is always accepted and the result arrives as a one-cycle strobe.
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier on a 32-bit carry-lookahead adder; 33-cycle latency.
// No backpressure: a new start aborts any operation in flight and the result is a one-cycle strobe.

// 8-bit lookahead block exporting group generate/propagate for the next lookahead level.
module booth_cla8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       g_o,
    output logic       p_o
);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic acc;
        acc = 1'b0;
        c   = '0;
        for (int i = 0; i < 8; i++) begin
            acc = c_i;
            for (int j = 0; j < i; j++) acc = g[j] | (p[j] & acc);
            c[i] = acc;
        end
    end

    assign s_o = p ^ c;

    always_comb begin
        g_o = 1'b0;
        p_o = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g_o = g[i] | (p[i] & g_o);
            p_o = p_o & p[i];
        end
    end
endmodule

module booth_cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] s_o,
    output logic        c_o
);
    logic [3:0] blk_g;
    logic [3:0] blk_p;
    logic [3:0] blk_c;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        booth_cla8 u_cla8 (
            .a_i (a_i[8*k +: 8]),
            .b_i (b_i[8*k +: 8]),
            .c_i (blk_c[k]),
            .s_o (s_o[8*k +: 8]),
            .g_o (blk_g[k]),
            .p_o (blk_p[k])
        );
    end

    always_comb begin
        logic acc;
        acc   = 1'b0;
        blk_c = '0;
        for (int k = 0; k < 4; k++) begin
            acc = c_i;
            for (int j = 0; j < k; j++) acc = blk_g[j] | (blk_p[j] & acc);
            blk_c[k] = acc;
        end
    end

    assign c_o = blk_g[3] | (blk_p[3] & blk_c[3]);
endmodule

module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    booth_multiplier_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [5:0] N_ITER  = 6'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [2*WIDTH:0] p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             do_op;
    logic             do_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   prod_hi;

    assign do_op  = p_q[1] ^ p_q[0];
    assign do_sub = p_q[1] & ~p_q[0];
    assign add_b  = do_sub ? ~m_q : m_q;

    booth_cla32 u_add (
        .a_i (p_q[2*WIDTH:WIDTH+1]),
        .b_i (add_b),
        .c_i (do_sub),
        .s_o (add_s),
        .c_o (add_co)
    );

    // The accumulator is kept one bit wider than the operands so that
    // subtracting 0x80000000 (i.e. adding +2^31) cannot overflow.
    assign acc = do_op ? {p_q[2*WIDTH] ^ add_b[WIDTH-1] ^ add_co, add_s}
                       : {p_q[2*WIDTH], p_q[2*WIDTH:WIDTH+1]};

    // Product bits 63:31 sit at P[64:32]; they must all match for a 32-bit fit.
    assign prod_hi = p_q[2*WIDTH:WIDTH];

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (bus.ctrl_MULT) begin
            state_d = ST_RUN;
            p_d     = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            m_d     = bus.data_operandA;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == N_ITER) begin
                        state_d  = ST_DONE;
                        result_d = p_q[WIDTH:1];
                        exc_d    = ~((&prod_hi) | ~(|prod_hi));
                        rdy_d    = 1'b1;
                    end else begin
                        p_d   = {acc, p_q[WIDTH:1]};
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random checks of booth_multiplier: products, overflow flag, latency, abort and reset.
module tb_booth_multiplier;
    logic clock = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    booth_multiplier_if #(.WIDTH(32)) bus ();

    booth_multiplier #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = b ^ 32'h5A5A_0F0F;
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_result"}, 64'(bus.data_result), 64'(exp_res));
        check({tag, "_exception"}, 64'(bus.data_exception), 64'(exp_exc));
        tick();
        check({tag, "_rdy_one_cycle"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, "_result_held"}, 64'(bus.data_result), 64'(exp_res));
    endtask

    initial begin
        int seen;
        logic [31:0]        ra, rb;
        logic signed [63:0] sa, sb, prod;
        logic [32:0]        top;

        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #2;
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_exception", 64'(bus.data_exception), 64'd0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        run_mult("3x4",        32'd3,         32'd4,         32'h0000_000C, 1'b0);
        run_mult("m7x6",       32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0);
        run_mult("maxx2",      32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1);
        run_mult("minxm1",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_mult("minxmin",    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        run_mult("minx1",      32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_mult("m1xm1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_mult("0xmax",      32'd0,         32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
        run_mult("4x8000",     32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 1'b1);

        // Abort: the second start at cycle 10 is the only one allowed to complete.
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd5;
        tick();
        bus.ctrl_MULT = 1'b0;
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        check("abort_no_early_rdy", 64'(seen), 64'd0);
        run_mult("abort_2xm3", 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0);

        // Reset mid-run: outputs clear without waiting for a clock edge.
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        tick();
        bus.ctrl_MULT = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset_result", 64'(bus.data_result), 64'd0);
        check("midrun_reset_exception", 64'(bus.data_exception), 64'd0);
        check("midrun_reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        check("no_rdy_after_reset", 64'(seen), 64'd0);
        check("result_still_zero", 64'(bus.data_result), 64'd0);

        // Start presented on the very first edge after reset release.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run_mult("first_edge_3x4", 32'd3, 32'd4, 32'h0000_000C, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 50 == 0) ra = 32'h8000_0000;
            if (i % 70 == 0) rb = 32'hFFFF_FFFF;
            if (i % 3 == 1) rb = rb >>> $urandom_range(0, 31);
            sa   = {{32{ra[31]}}, ra};
            sb   = {{32{rb[31]}}, rb};
            prod = sa * sb;
            top  = prod[63:31];
            run_mult("random", ra, rb, prod[31:0], ~((&top) | ~(|top)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width; only 32 is supported and verified.
REQ-002 The block SHALL have this port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have this port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have this port: ctrl_MULT  input  1  start pulse; sampled on the rising edge.
REQ-005 The block SHALL have this port: data_operandA  input  32  signed multiplicand; sampled only when ctrl_MULT=1.
REQ-006 The block SHALL have this port: data_operandB  input  32  signed multiplier; sampled only when ctrl_MULT=1.
REQ-007 The block SHALL have this port: data_result  output  32  low 32 bits of the signed product.
REQ-008 The block SHALL have this port: data_exception  output  1  signed overflow flag, valid while data_resultRDY=1.
REQ-009 The block SHALL have this port: data_resultRDY  output  1  one-cycle completion strobe.

Function
REQ-010 The block SHALL implement radix-2 Booth multiplication as the consumer of the team's 32-bit carry-lookahead adder (four 8-bit lookahead blocks, carry-in used for subtract).
REQ-011 Booth state SHALL be: product register P[64:0] = {32'b0, B, 1'b0}, multiplicand register M = A, and 6-bit iteration counter.
REQ-012 Each iteration SHALL do the following: P[1:0]=01 adds M to P[64:33]; 10 subtracts M (adder with ~M, carry-in 1); 00/11 makes no change; then arithmetic-shift-right P by 1.
REQ-013 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-014 IDLE SHALL transition to RUN when ctrl_MULT=1: load M, P, and counter=0.
REQ-015 RUN SHALL perform one iteration per cycle and increment the counter; after the 32nd iteration (counter=31) it SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle with data_resultRDY=1, then return to IDLE.
REQ-017 Latency SHALL be 33 cycles: ctrl_MULT sampled at edge E0 gives data_resultRDY high from edge E33 to edge E34.
REQ-018 data_result SHALL equal P[32:1] and be registered at entry to DONE; it SHALL hold until the next completion or reset.
REQ-019 data_exception SHALL be 1 iff the 64-bit signed product is not representable in 32 bits (bits 63:31 not all equal); it SHALL be registered with data_result and held with it.
REQ-020 ctrl_MULT=1 during RUN or DONE SHALL abort the current operation, reload operands, and restart at counter=0; no data_resultRDY is produced for the aborted operation.
REQ-021 Operand inputs SHALL be ignored except on ctrl_MULT edges; changes during RUN SHALL not affect the result.
REQ-022 Back-to-back ctrl_MULT in consecutive cycles SHALL each restart, so only the last start completes.
REQ-023 Arithmetic wrap-around SHALL be two's complement; the most negative operand (0x80000000) SHALL be handled without special cases via the 33-bit sign-extended upper accumulator.

Reset
REQ-024 reset_n=0 SHALL immediately (asynchronously) force: FSM to IDLE; counter, P, and M to 0; data_result to 0x00000000; data_exception to 0; data_resultRDY to 0.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; after release no data_resultRDY SHALL occur until a new ctrl_MULT.
REQ-026 After reset_n deasserts, the first rising edge SHALL sample ctrl_MULT normally.

Verification
REQ-027 Verification SHALL cover: A=3, B=4, start -> exactly 33 cycles later data_resultRDY=1 for 1 cycle, data_result=0x0000000C, data_exception=0.
REQ-028 Verification SHALL cover: A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), data_exception=0.
REQ-029 Verification SHALL cover: A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1; and A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1.
REQ-030 Verification SHALL cover: start A=5, B=5; at cycle 10 start A=2, B=-3 -> single data_resultRDY 33 cycles after the second start, data_result=0xFFFFFFFA.
REQ-031 Verification SHALL cover: start A=9, B=9; drop reset_n at cycle 15 -> outputs 0 immediately, no data_resultRDY for 50 cycles after release.
REQ-032 Verification SHALL cover: randomized 1000 signed operand pairs -> data_result and data_exception match 64-bit reference product, with latency always 33 cycles.
